// File: rtl/updown_counter_param.sv
// Parametrised up/down counter over [MIN_VAL, MAX_VAL] with programmable step,
// synchronous clamped load, wrap/saturate boundary modes and registered carry/borrow pulses.
module updown_counter_param #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] MIN_VAL   = '0,
   parameter logic [WIDTH-1:0] MAX_VAL   = '1,
   parameter logic [WIDTH-1:0] RESET_VAL = MIN_VAL
) (
   input  logic             Clk,
   input  logic             reset_n,
   input  logic             En,
   input  logic             UpOrDown,
   input  logic [WIDTH-1:0] Step,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   input  logic             SatMode,
   output logic [WIDTH-1:0] Count,
   output logic             Carry,
   output logic             Borrow,
   output logic             AtMax,
   output logic             AtMin
);

   localparam logic [WIDTH:0] MIN_X = {1'b0, MIN_VAL};
   localparam logic [WIDTH:0] MAX_X = {1'b0, MAX_VAL};
   localparam logic [WIDTH:0] SPAN  = MAX_X - MIN_X + 1'b1;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             below;
   logic [WIDTH-1:0] next_count;
   logic             next_carry;
   logic             next_borrow;

   always_comb begin
      next_count  = Count;
      next_carry  = 1'b0;
      next_borrow = 1'b0;
      sum         = {1'b0, Count} + {1'b0, Step};
      diff        = {1'b0, Count} - {1'b0, Step};
      // diff is two's complement in WIDTH+1 bits: a set top bit means it went negative
      below       = diff[WIDTH] || (diff < MIN_X);
      if (Load) begin
         if (LoadVal < MIN_VAL)
            next_count = MIN_VAL;
         else if (LoadVal > MAX_VAL)
            next_count = MAX_VAL;
         else
            next_count = LoadVal;
      end else if (En) begin
         if (UpOrDown) begin
            if (sum <= MAX_X) begin
               next_count = sum[WIDTH-1:0];
            end else begin
               next_carry = 1'b1;
               next_count = SatMode ? MAX_VAL : WIDTH'(sum - SPAN);
            end
         end else begin
            if (!below) begin
               next_count = diff[WIDTH-1:0];
            end else begin
               next_borrow = 1'b1;
               next_count  = SatMode ? MIN_VAL : WIDTH'(diff + SPAN);
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         Count  <= RESET_VAL;
         Carry  <= 1'b0;
         Borrow <= 1'b0;
      end else begin
         Count  <= next_count;
         Carry  <= next_carry;
         Borrow <= next_borrow;
      end
   end

   assign AtMax = (Count == MAX_VAL);
   assign AtMin = (Count == MIN_VAL);

   // A step wider than the range would skip past a whole wrap period
   step_legal: assert property (@(posedge Clk) disable iff (!reset_n)
      (En && !Load) |-> ({1'b0, Step} <= (MAX_X - MIN_X)))
      else $error("updown_counter_param: Step exceeds MAX_VAL-MIN_VAL");

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param at WIDTH=4, range [2,11], reset value 2.
module tb_updown_counter_param;

   logic       Clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       En = 1'b0;
   logic       UpOrDown = 1'b1;
   logic [3:0] Step = 4'd1;
   logic       Load = 1'b0;
   logic [3:0] LoadVal = 4'd0;
   logic       SatMode = 1'b0;
   logic [3:0] Count;
   logic       Carry;
   logic       Borrow;
   logic       AtMax;
   logic       AtMin;

   int unsigned errors = 0;
   int unsigned checks = 0;

   updown_counter_param #(
      .WIDTH(4),
      .MIN_VAL(4'd2),
      .MAX_VAL(4'd11),
      .RESET_VAL(4'd2)
   ) dut (
      .Clk(Clk),
      .reset_n(reset_n),
      .En(En),
      .UpOrDown(UpOrDown),
      .Step(Step),
      .Load(Load),
      .LoadVal(LoadVal),
      .SatMode(SatMode),
      .Count(Count),
      .Carry(Carry),
      .Borrow(Borrow),
      .AtMax(AtMax),
      .AtMin(AtMin)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [3:0] c, input logic cy, input logic bw);
      check({tag, ".count"}, Count, c);
      check({tag, ".carry"}, Carry, cy);
      check({tag, ".borrow"}, Borrow, bw);
   endtask

   initial begin
      logic [3:0] exp_cnt;
      logic       exp_cy;

      // asynchronous reset from time zero
      #1 reset_n = 1'b0;
      #1;
      check_state("reset", 4'd2, 1'b0, 1'b0);
      check("reset.at_min", AtMin, 1'b1);
      check("reset.at_max", AtMax, 1'b0);
      tick();
      reset_n = 1'b1;

      // wrap up by 1 through 11 -> 2
      En = 1'b1; UpOrDown = 1'b1; Step = 4'd1; SatMode = 1'b0;
      exp_cnt = 4'd2;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (exp_cnt == 4'd11) begin
            exp_cnt = 4'd2; exp_cy = 1'b1;
         end else begin
            exp_cnt = exp_cnt + 4'd1; exp_cy = 1'b0;
         end
         check_state("wrap_up", exp_cnt, exp_cy, 1'b0);
         check("wrap_up.at_max", AtMax, exp_cnt == 4'd11);
      end

      // wrap down with step 3 from 4
      Load = 1'b1; LoadVal = 4'd4;
      tick();
      check_state("load4", 4'd4, 1'b0, 1'b0);
      Load = 1'b0; Step = 4'd3; UpOrDown = 1'b0;
      tick();
      check_state("wrap_dn", 4'd11, 1'b0, 1'b1);
      tick();
      check_state("wrap_dn2", 4'd8, 1'b0, 1'b0);

      // saturate up from 10 with step 3
      SatMode = 1'b1; Load = 1'b1; LoadVal = 4'd10;
      tick();
      check_state("load10", 4'd10, 1'b0, 1'b0);
      Load = 1'b0; UpOrDown = 1'b1;
      tick();
      check_state("sat_up1", 4'd11, 1'b1, 1'b0);
      tick();
      check_state("sat_up2", 4'd11, 1'b1, 1'b0);
      tick();
      check_state("sat_up3", 4'd11, 1'b1, 1'b0);
      En = 1'b0;
      tick();
      check_state("sat_hold", 4'd11, 1'b0, 1'b0);

      // load wins over a saturating enable and clamps high
      En = 1'b1;
      tick();
      check("sat_again.carry", Carry, 1'b1);
      Load = 1'b1; LoadVal = 4'd15;
      tick();
      check_state("load_clamp_hi", 4'd11, 1'b0, 1'b0);
      LoadVal = 4'd0;
      tick();
      check_state("load_clamp_lo", 4'd2, 1'b0, 1'b0);
      Load = 1'b0; En = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_state("idle_hold", 4'd2, 1'b0, 1'b0);
      end

      // saturate down at MIN
      En = 1'b1; UpOrDown = 1'b0; Step = 4'd3;
      tick();
      check_state("sat_dn", 4'd2, 1'b0, 1'b1);

      // direction switch, then zero step
      SatMode = 1'b0; UpOrDown = 1'b1; Step = 4'd1;
      for (int i = 3; i <= 6; i++) begin
         tick();
         check_state("dir_up", 4'(i), 1'b0, 1'b0);
      end
      UpOrDown = 1'b0;
      tick();
      check_state("dir_dn", 4'd5, 1'b0, 1'b0);
      Step = 4'd0;
      tick();
      check_state("step0", 4'd5, 1'b0, 1'b0);

      // reset mid-count between edges with a load pending
      Step = 4'd1; Load = 1'b1; LoadVal = 4'd7;
      tick();
      check_state("load7", 4'd7, 1'b0, 1'b0);
      LoadVal = 4'd10;
      #3 reset_n = 1'b0;
      #1;
      check_state("async_rst", 4'd2, 1'b0, 1'b0);
      check("async_rst.at_min", AtMin, 1'b1);
      tick();
      check_state("rst_held", 4'd2, 1'b0, 1'b0);
      reset_n = 1'b1;
      tick();
      check_state("post_rst_load", 4'd10, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised up/down counter. It generalises the team's fixed 4-bit up/down counter.
- Adds the following over the 4-bit version:
  - configurable width and count range [MIN_VAL, MAX_VAL]
  - programmable step
  - synchronous load
  - count enable
  - wrap or saturate mode
  - registered carry/borrow event flags
- Used as a general-purpose timebase, address and modulo counter in datapath and control blocks.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MIN_VAL, 0, lowest count value. Must satisfy 0 <= MIN_VAL < MAX_VAL.
- MAX_VAL, 2**WIDTH-1, highest count value. Must satisfy MAX_VAL <= 2**WIDTH-1.
- RESET_VAL, MIN_VAL, value taken on reset. Must lie in [MIN_VAL, MAX_VAL].

Ports:
- Clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- En  input  1  count enable; the counter advances only when high.
- UpOrDown  input  1  direction: 1 = up, 0 = down.
- Step  input  WIDTH  increment/decrement amount. Legal range 1..(MAX_VAL-MIN_VAL).
- Load  input  1  synchronous load strobe.
- LoadVal  input  WIDTH  value to load.
- SatMode  input  1  boundary mode: 0 = wrap, 1 = saturate.
- Count  output  WIDTH  current count, registered.
- Carry  output  1  one-cycle registered pulse: up-count crossed MAX_VAL.
- Borrow  output  1  one-cycle registered pulse: down-count crossed MIN_VAL.
- AtMax  output  1  combinational: Count == MAX_VAL.
- AtMin  output  1  combinational: Count == MIN_VAL.

Behaviour:
- Reset:
  - reset_n low forces Count = RESET_VAL, Carry = 0, Borrow = 0 immediately, independent of Clk.
  - Release is synchronised by the system; the first count edge is the first rising Clk after release.
  - Reset asserted mid-count overrides everything, including a pending Load.
- Priority at each rising Clk (reset_n high): Load > En > hold.
- Load:
  - Count <= LoadVal, clamped: values < MIN_VAL load MIN_VAL; values > MAX_VAL load MAX_VAL.
  - Carry and Borrow are 0 that cycle. Load ignores En, UpOrDown and SatMode.
- En = 1, UpOrDown = 1:
  - Compute sum in WIDTH+1 bits: s = Count + Step.
  - If s <= MAX_VAL: Count <= s.
  - Else, SatMode = 0: Count <= s - (MAX_VAL-MIN_VAL+1), Carry <= 1.
  - Else, SatMode = 1: Count <= MAX_VAL, Carry <= 1. This includes the case Count already == MAX_VAL, so Carry repeats each enabled cycle while saturated.
- En = 1, UpOrDown = 0:
  - Compute d = Count - Step, signed, WIDTH+1 bits.
  - If d >= MIN_VAL: Count <= d.
  - Else, SatMode = 0: Count <= d + (MAX_VAL-MIN_VAL+1), Borrow <= 1.
  - Else, SatMode = 1: Count <= MIN_VAL, Borrow <= 1.
- En = 0 and Load = 0: Count holds; Carry = Borrow = 0.
- Carry and Borrow:
  - Registered, valid in the cycle after the edge that caused them.
  - Never both 1.
  - Deasserted by any non-crossing cycle.
- Latency:
  - Count updates at the same edge as the qualifying inputs.
  - AtMax/AtMin follow Count combinationally.
- Direction or SatMode changes take effect on the next edge; there is no internal state besides Count, Carry and Borrow.
- Step = 0 is a defined no-op: Count holds, no flags.
- Step > MAX_VAL-MIN_VAL is illegal. It is flagged by a simulation-only assertion; RTL behaviour is unspecified.
- No combinational path from inputs to Count, Carry or Borrow.

Test Plan (parameters WIDTH=4, MIN_VAL=2, MAX_VAL=11, RESET_VAL=2):
- Reset: hold reset_n=0 mid-count at Count=7, asserted asynchronously between edges -> Count=2, Carry=0, Borrow=0 immediately; AtMin=1.
- Wrap up: Step=1, UpOrDown=1, En=1, SatMode=0, 12 edges from 2 -> sequence 3..11, then 2; Carry pulses exactly once, the cycle after 11->2.
- Wrap down with step: load 4, Step=3, UpOrDown=0 -> Count 4 -> 11 (4-3=1 < 2, so 1+10=11) with Borrow=1; next edge 11 -> 8, Borrow=0.
- Saturate: SatMode=1, load 10, Step=3, up -> Count=11, Carry=1. Further enabled edges -> Count stays 11, Carry=1 each cycle. En=0 -> Carry=0.
- Load priority/clamp:
  - Load=1 with En=1 and LoadVal=15 -> Count=11, no flags.
  - LoadVal=0 -> Count=2.
  - Load=0 and En=0 for 5 edges -> Count unchanged.
- Direction switch: count up 2->6 with Step=1, flip UpOrDown=0 -> next edge 5. Step=0 with En=1 -> Count holds at 5, no flags.
